// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of an external 8-bit ALU: reads operands from a 4x8 regfile, captures and writes back the result.
// Latency: accept edge N drives operands; writeback and out_done at edge N+1; one instruction per 2 cycles.
// Backpressure: out_instr_ready is low for the single EXEC cycle; the source holds valid/instr until accepted.
module alu_issue_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_instr_valid,
  input  logic [7:0] in_instr,
  output logic       out_instr_ready,
  input  logic       in_wr_en,
  input  logic [1:0] in_wr_addr,
  input  logic [7:0] in_wr_data,
  input  logic [1:0] in_rd_addr,
  output logic [7:0] out_rd_data,
  output logic [7:0] out_alu_A,
  output logic [7:0] out_alu_B,
  output logic [1:0] out_alu_op,
  input  logic [7:0] in_alu_c,
  output logic [7:0] out_result,
  output logic       out_zero,
  output logic       out_done
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rf_q [0:3];
  logic [7:0] rf_d [0:3];
  logic [1:0] rd_q;
  logic [7:0] alu_a_q, alu_b_q;
  logic [1:0] alu_op_q;
  logic [7:0] result_q;
  logic       zero_q;
  logic       done_q;
  logic       accept;

  // instruction field decode
  logic [1:0] instr_op, instr_rd, instr_rs1, instr_rs2;
  assign instr_op  = in_instr[7:6];
  assign instr_rd  = in_instr[5:4];
  assign instr_rs1 = in_instr[3:2];
  assign instr_rs2 = in_instr[1:0];

  assign accept = in_instr_valid && (state_q == IDLE);

  // next state: accept moves to EXEC, EXEC always retires in one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_instr_valid) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // regfile next contents: load port first, ALU writeback overrides a same-address load
  always_comb begin
    rf_d = rf_q;
    if (in_wr_en) rf_d[in_wr_addr] = in_wr_data;
    if (state_q == EXEC) rf_d[rd_q] = in_alu_c;
  end

  // state, regfile, operand and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rf_q     <= '{default: 8'h00};
      rd_q     <= 2'b00;
      alu_a_q  <= 8'h00;
      alu_b_q  <= 8'h00;
      alu_op_q <= 2'b00;
      result_q <= 8'h00;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      done_q  <= 1'b0;
      if (accept) begin
        // operands come from pre-edge contents, so a same-edge load is not seen
        rd_q     <= instr_rd;
        alu_a_q  <= rf_q[instr_rs1];
        alu_b_q  <= rf_q[instr_rs2];
        alu_op_q <= instr_op;
      end
      if (state_q == EXEC) begin
        result_q <= in_alu_c;
        zero_q   <= (in_alu_c == 8'h00);
        done_q   <= 1'b1;
      end
    end
  end

  assign out_instr_ready = (state_q == IDLE);
  assign out_rd_data     = rf_q[in_rd_addr];
  assign out_alu_A       = alu_a_q;
  assign out_alu_B       = alu_b_q;
  assign out_alu_op      = alu_op_q;
  assign out_result      = result_q;
  assign out_zero        = zero_q;
  assign out_done        = done_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing front end for the 8-bit ALU: accepts packed register-to-register instructions over a valid/ready handshake and reads both operands from a 4-entry × 8-bit register file. It drives the ALU's operand/operation inputs, captures the ALU result, and writes it back. It sits between instruction fetch and the combinational ALU, owning the ALU's input side and its result capture. The ALU itself stays external.

## Interface
- No parameters; data width fixed at 8, register file fixed at 4 entries.
- clk  in  1  sole clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_instr_valid  in  1  instruction offered.
- in_instr  in  8  [7:6] op (00 AND, 01 OR, 10 ADD, 11 SUB), [5:4] rd, [3:2] rs1, [1:0] rs2.
- out_instr_ready  out  1  instruction accepted when valid & ready at a rising edge.
- in_wr_en / in_wr_addr / in_wr_data  in  1/2/8  direct register-file load port.
- in_rd_addr  in  2  debug read address.
- out_rd_data  out  8  combinational regfile[in_rd_addr].
- out_alu_A / out_alu_B  out  8  registered operands to ALU in_A / in_B.
- out_alu_op  out  2  registered operation to ALU in_operation.
- in_alu_c  in  8  ALU result (ALU out_c), sampled combinationally.
- out_result  out  8  last written-back result.
- out_zero  out  1  out_result == 0, registered with it.
- out_done  out  1  one-cycle pulse per completed instruction.

## Operation
- FSM has two states: IDLE and EXEC. out_instr_ready = (state == IDLE), combinational.
- IDLE, accept edge:
  - latch op and rd.
  - load out_alu_A ← regfile[rs1] and out_alu_B ← regfile[rs2], using pre-edge contents.
  - load out_alu_op ← op.
  - go to EXEC.
- EXEC, next edge:
  - regfile[rd] ← in_alu_c, out_result ← in_alu_c, out_zero ← (in_alu_c == 0), out_done ← 1.
  - go to IDLE.
- out_done is cleared on every edge where it is not set.
- out_alu_A/B/op hold their values after EXEC until the next accept.
- The block does no arithmetic itself; result width is 8 bits, with wrap-around as produced by the ALU.
- Load port: the write occurs on any edge with in_wr_en, in either state.
  - A write on the same edge as an accept does not affect the operands read; no bypass.
  - A write to rd on the EXEC writeback edge loses; ALU writeback wins.
  - A write to another address on that edge is performed.
- rs1 == rs2 and rd == rs1/rs2 are legal; operands are read before writeback.
- in_instr is ignored while in EXEC. The upstream source must hold valid and instruction until accepted.

## Timing
- Reset (async assert, sync-safe deassert edge): state IDLE, regfile all 0x00, out_alu_A/B 0x00, out_alu_op 00, out_result 0x00, out_zero 1, out_done 0, out_instr_ready 1.
- Accept at edge N; operands stable on the ALU during cycle N→N+1.
- Writeback at edge N+1; out_done high during cycle N+1→N+2.
- Throughput is one instruction per 2 cycles.
  - With valid held high, the next accept occurs at edge N+2.
  - Back-to-back dependent instructions see the prior result; no hazard.
- Reset asserted during EXEC aborts the instruction: no writeback, no out_done, all outputs return to reset values immediately.
- out_rd_data reflects regfile contents after the most recent edge, with no extra delay.

## Test plan
- Reset then idle:
  - all outputs at reset values, out_zero=1, out_instr_ready=1.
  - out_rd_data=0x00 for every address.
- Load R0=0xF0 and R1=0x3C via the write port.
  - Issue AND R2,R0,R1 (in_instr=0x21); the bench ALU model returns 0x30.
  - Required: out_alu_A=0xF0, out_alu_B=0x3C, op=00.
  - Required: out_done one cycle later, R2=0x30, out_zero=0.
- Wrap and zero: R0=0xFF, R1=0x01.
  - ADD R3,R0,R1 (0xB1) → R3=0x00, out_zero=1.
  - SUB R3,R1,R1 (0xF5) → 0x00.
- Hold valid high for OR R0,R0,R1 then ADD R1,R0,R0.
  - Required: accepts exactly 2 cycles apart; second instruction uses the updated R0.
  - Required: out_instr_ready=0 during each EXEC.
- Collisions:
  - in_wr_en to rd on the writeback edge → the ALU result is stored.
  - Write to rs1 on the accept edge → the old value appears on out_alu_A.
- Assert reset_n=0 mid-EXEC:
  - rd remains 0x00 after release, out_done never pulses.
  - out_instr_ready=1 immediately.
